// File: rtl/cpu_pkg.sv
// Shared opcodes, ALU select encoding and instruction field positions for the cpu core.
package cpu_pkg;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_BNE   = 8'h08;

  typedef enum logic [1:0] {
    ALU_FWD = 2'd0,
    ALU_ADD = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_sel_e;

  localparam int OPC_LSB  = 24;
  localparam int DEST_LSB = 16;
  localparam int SRC1_LSB = 8;
  localparam int SRC2_LSB = 0;
  localparam int FIELD_W  = 8;
  localparam int REG_AW   = 3;

endpackage

// File: rtl/cpu_reg_file.sv
// 8 x 8-bit register file: two combinational read ports, one synchronous write port.
// Reads of the register being written return the old value until the edge.
module cpu_reg_file
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [7:0]        rdata1,
  output logic [7:0]        rdata2,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [7:0]        wdata
);

  logic [7:0] regs [8];

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/cpu.sv
// Single-cycle 8-bit core with 32-bit byte-addressed PC and inline decode/ALU/PC logic.
// Optional bne opcode (0x08) is enabled by defining CPU_BNE_EN.
module cpu
  import cpu_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  output logic [31:0] PC_OUT
);

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] pc_target;

  logic [7:0] opcode;
  logic [7:0] dest;
  logic [7:0] src1;
  logic [7:0] src2;

  logic [7:0] rdata1;
  logic [7:0] rdata2;
  logic [7:0] operand_b;
  logic [7:0] operand_b_eff;
  logic [7:0] sum;
  logic [7:0] alu_result;
  logic       zero;

  alu_sel_e alu_sel;
  logic     reg_we;
  logic     use_imm;
  logic     sub_en;
  logic     take_branch;

  logic unused_fields;

  assign opcode = INSTRUCTION[OPC_LSB  +: FIELD_W];
  assign dest   = INSTRUCTION[DEST_LSB +: FIELD_W];
  assign src1   = INSTRUCTION[SRC1_LSB +: FIELD_W];
  assign src2   = INSTRUCTION[SRC2_LSB +: FIELD_W];

  assign unused_fields = ^src1[7:REG_AW];

  cpu_reg_file u_rf (
    .clk    (CLK),
    .reset  (RESET),
    .raddr1 (src1[REG_AW-1:0]),
    .raddr2 (src2[REG_AW-1:0]),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .we     (reg_we),
    .waddr  (dest[REG_AW-1:0]),
    .wdata  (alu_result)
  );

  always_comb begin
    alu_sel     = ALU_FWD;
    reg_we      = 1'b0;
    use_imm     = 1'b0;
    sub_en      = 1'b0;
    take_branch = 1'b0;
    case (opcode)
      OP_LOADI: begin reg_we = 1'b1; use_imm = 1'b1; end
      OP_MOV:   reg_we = 1'b1;
      OP_ADD:   begin reg_we = 1'b1; alu_sel = ALU_ADD; end
      OP_SUB:   begin reg_we = 1'b1; alu_sel = ALU_ADD; sub_en = 1'b1; end
      OP_AND:   begin reg_we = 1'b1; alu_sel = ALU_AND; end
      OP_OR:    begin reg_we = 1'b1; alu_sel = ALU_OR; end
      OP_J:     take_branch = 1'b1;
      OP_BEQ:   begin alu_sel = ALU_ADD; sub_en = 1'b1; take_branch = zero; end
`ifdef CPU_BNE_EN
      OP_BNE:   begin alu_sel = ALU_ADD; sub_en = 1'b1; take_branch = !zero; end
`endif
      default:  ;
    endcase
  end

  // Subtract is add of the two's complement: invert B and carry in one.
  assign operand_b     = use_imm ? src2 : rdata2;
  assign operand_b_eff = sub_en ? ~operand_b : operand_b;
  assign sum           = rdata1 + operand_b_eff + {7'b0, sub_en};
  assign zero          = (sum == 8'h00);

  always_comb begin
    alu_result = operand_b;
    case (alu_sel)
      ALU_FWD: alu_result = operand_b;
      ALU_ADD: alu_result = sum;
      ALU_AND: alu_result = rdata1 & operand_b;
      ALU_OR:  alu_result = rdata1 | operand_b;
      default: alu_result = operand_b;
    endcase
  end

  assign pc_plus4  = pc + 32'd4;
  assign pc_target = pc_plus4 + {{22{dest[7]}}, dest, 2'b00};
  assign pc_next   = take_branch ? pc_target : pc_plus4;

  always_ff @(posedge CLK) begin
    if (RESET) pc <= 32'h0;
    else       pc <= pc_next;
  end

  assign PC_OUT = pc;

endmodule

// File: tb/tb_cpu.sv
// Scoreboard bench for cpu: driver feeds directed then random instructions, a
// reference model queues the expected post-edge PC and registers, a monitor compares.
module tb_cpu;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] INSTRUCTION = 32'hFF00_0000;
  logic [31:0] PC_OUT;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] regs;
  } exp_t;

  exp_t sb_q[$];

  logic [31:0] m_pc;
  logic [7:0]  m_r [8];

  cpu dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .INSTRUCTION (INSTRUCTION),
    .PC_OUT      (PC_OUT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] enc(input int op, input int d, input int s1, input int s2);
    return {op[7:0], d[7:0], s1[7:0], s2[7:0]};
  endfunction

  function automatic logic [63:0] pack_model();
    logic [63:0] p;
    for (int i = 0; i < 8; i++) p[i*8 +: 8] = m_r[i];
    return p;
  endfunction

  // Behavioural model: one architectural instruction per call.
  task automatic model_step(input logic rst, input logic [31:0] ins);
    int op, a, b, d, off;
    byte sb;
    logic take;
    if (rst) begin
      m_pc = 0;
      for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
      return;
    end
    op = int'(ins[31:24]);
    d  = int'(ins[18:16]);
    a  = int'(m_r[ins[10:8]]);
    b  = int'(m_r[ins[2:0]]);
    sb = ins[23:16];
    off = sb;
    take = 1'b0;
    case (op)
      0: m_r[d] = ins[7:0];
      1: m_r[d] = 8'(b);
      2: m_r[d] = 8'((a + b) % 256);
      3: m_r[d] = 8'((a - b + 256) % 256);
      4: m_r[d] = 8'(a & b);
      5: m_r[d] = 8'(a | b);
      6: take = 1'b1;
      7: take = (a == b);
`ifdef CPU_BNE_EN
      8: take = (a != b);
`endif
      default: ;
    endcase
    if (take) m_pc = m_pc + 32'(4 + off * 4);
    else      m_pc = m_pc + 32'd4;
  endtask

  task automatic step(input logic rst, input logic [31:0] ins);
    @(negedge CLK);
    RESET = rst;
    INSTRUCTION = ins;
    model_step(rst, ins);
    sb_q.push_back('{pc: m_pc, regs: pack_model()});
  endtask

  // Monitor: after each rising edge, compare against the oldest queued expectation.
  initial begin
    exp_t e;
    logic [63:0] act;
    forever begin
      @(posedge CLK);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        for (int i = 0; i < 8; i++) act[i*8 +: 8] = dut.u_rf.regs[i];
        checks++;
        if (PC_OUT !== e.pc) begin
          errors++;
          $display("FAIL pc: got %08h expected %08h", PC_OUT, e.pc);
        end
        checks++;
        if (act !== e.regs) begin
          errors++;
          $display("FAIL regs: got %016h expected %016h", act, e.regs);
        end
      end
    end
  end

  initial begin
    logic [31:0] ins;
    int op;
    step(1'b1, 32'hFF00_0000);
    step(1'b1, 32'hFF00_0000);
    step(1'b0, enc(8'hFF, 0, 0, 0));
    step(1'b0, enc(8'hFF, 0, 0, 0));
    step(1'b0, enc(8'hFF, 0, 0, 0));
    step(1'b0, enc(0, 1, 0, 5));
    step(1'b0, enc(0, 2, 0, 3));
    step(1'b0, enc(2, 3, 1, 2));
    step(1'b0, enc(3, 4, 2, 1));
    step(1'b0, enc(4, 5, 1, 2));
    step(1'b0, enc(5, 6, 1, 2));
    step(1'b0, enc(1, 7, 0, 3));
    step(1'b0, enc(0, 1, 0, 8'hFF));
    step(1'b0, enc(2, 1, 1, 1));
    step(1'b0, enc(6, 2, 0, 0));
    step(1'b0, enc(6, 8'hFF, 0, 0));
    step(1'b0, enc(6, 8'hFF, 0, 0));
    step(1'b0, enc(0, 2, 0, 8'hFE));
    step(1'b0, enc(7, 1, 1, 2));
    step(1'b0, enc(7, 1, 1, 3));
    step(1'b0, enc(8'h0F, 3, 1, 2));
    step(1'b0, enc(8'h08, 2, 1, 3));
    step(1'b0, enc(8'h08, 2, 1, 2));
    step(1'b0, enc(0, 8'hF9, 8'hFA, 8'h5A));
    step(1'b0, enc(6, 8'h80, 0, 0));
    step(1'b1, enc(0, 1, 0, 8'h77));
    step(1'b0, enc(6, 8'hF0, 0, 0));
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) op = int'($urandom_range(9, 255));
      else                           op = int'($urandom_range(0, 8));
      ins = {op[7:0], 8'($urandom), 8'($urandom), 8'($urandom)};
      step($urandom_range(0, 49) == 0, ins);
    end
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
